// File: rtl/aes_pkg.sv
// Shared AES / GF(2^8) definitions for the S-box datapath: field constants,
// lookup FSM states and small combinational helpers.
package aes_pkg;

  localparam logic [7:0] AES_SBOX_C  = 8'h63;
  localparam logic [7:0] GF_POLY_LOW = 8'h1b;
  localparam logic [7:0] GF_GEN      = 8'h03;
  localparam logic [7:0] GF_GEN_INV  = 8'hf6;
  localparam logic [7:0] SCAN_LAST   = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY_LOW : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = gf_xtime(x);
    end
    return acc;
  endfunction

  // Forward S-box affine map applied to an already inverted byte.
  function automatic logic [7:0] aes_affine(input logic [7:0] v);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ AES_SBOX_C;
  endfunction

endpackage

// File: rtl/gf256_walk.sv
// Walks p through powers of 0x03 while q tracks p^-1, so aff = S(p) each cycle
// without a field inversion; shared with the forward S-box.
module gf256_walk
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  output logic [7:0] p,
  output logic [7:0] aff
);

  logic [7:0] p_q, p_d;
  logic [7:0] q_q, q_d;

  always_comb begin
    p_d = p_q;
    q_d = q_q;
    if (clear) begin
      p_d = 8'h01;
      q_d = 8'h01;
    end else if (step) begin
      p_d = gf_mul(p_q, GF_GEN);
      q_d = gf_mul(q_q, GF_GEN_INV);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      p_q <= 8'h01;
      q_q <= 8'h01;
    end else begin
      p_q <= p_d;
      q_q <= q_d;
    end
  end

  assign p   = p_q;
  assign aff = aes_affine(q_q);

endmodule

// File: rtl/inv_sbox.sv
// Iterative AES inverse S-box over NBYTES lanes: every lane watches the shared
// S(p) walk and latches p when it sees its own byte.
module inv_sbox
  import aes_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [8*NBYTES-1:0]   index,
  output logic [8*NBYTES-1:0]   sbout,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [8*NBYTES-1:0]   idx_q, idx_d;
  logic [8*NBYTES-1:0]   sbout_q, sbout_d;
  logic [NBYTES-1:0]     found_q, found_d;
  logic [7:0]            cnt_q, cnt_d;

  logic [7:0]            p;
  logic [7:0]            aff;
  logic                  walk_step;
  logic [NBYTES-1:0]     hit;
  logic [8*NBYTES-1:0]   sbout_scan;

  assign walk_step = (state_q == ST_SCAN) && enable;

  gf256_walk u_walk (
    .clk    (clk),
    .resetn (resetn),
    .clear  (!walk_step),
    .step   (walk_step),
    .p      (p),
    .aff    (aff)
  );

  // 0x63 has preimage 0x00, which the multiplicative walk never visits.
  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    logic [7:0] b;
    assign b       = idx_q[8*i +: 8];
    assign hit[i]  = !found_q[i] && ((b == AES_SBOX_C) || (b == aff));
    assign sbout_scan[8*i +: 8] = !hit[i] ? sbout_q[8*i +: 8] :
                                  ((b == AES_SBOX_C) ? 8'h00 : p);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sbout_d = sbout_q;
    found_d = found_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          idx_d   = index;
          sbout_d = '0;
          found_d = '0;
          cnt_d   = 8'd0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          found_d = '0;
          state_d = ST_IDLE;
        end else begin
          sbout_d = sbout_scan;
          found_d = found_q | hit;
          cnt_d   = cnt_q + 8'd1;
          if ((&found_d) || (cnt_q == SCAN_LAST)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          found_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sbout_q <= '0;
      found_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sbout_q <= sbout_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
    end
  end

  // The S-box is a bijection, so the last walk step must resolve every lane.
  a_scan_complete: assert property (@(posedge clk) disable iff (!resetn)
    (walk_step && cnt_q == SCAN_LAST) |-> (&found_d));

  assign sbout = sbout_q;
  assign busy  = (state_q == ST_SCAN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_inv_sbox.sv
// Bench for inv_sbox: reference S-box built from GF(2^8) arithmetic, random and
// exhaustive lookups, abort, reset and index-stability scenarios.
module tb_inv_sbox;

  localparam int NB = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic [8*NB-1:0]   index = '0;
  logic [8*NB-1:0]   sbout;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];
  int         pos_m  [256];

  always #5 clk = ~clk;

  inv_sbox #(.NBYTES(NB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .index  (index),
    .sbout  (sbout),
    .busy   (busy),
    .done   (done)
  );

  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_exclusive: busy=%0b done=%0b, required not both high", busy, done);
      end
    end
  end

  // Polynomial product then reduction by x^8+x^4+x^3+x+1.
  function automatic int mmul(input int a, input int b);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if ((b >> i) & 1) r = r ^ (a << i);
    for (int k = 14; k >= 8; k--)
      if ((r >> k) & 1) r = r ^ (32'h11b << (k - 8));
    return r;
  endfunction

  task automatic init_model();
    int y, s, e, bi;
    for (int x = 0; x < 256; x++) begin
      y = 0;
      if (x != 0)
        for (int c = 1; c < 256; c++)
          if (mmul(x, c) == 1) y = c;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        bi = ((y >> i) ^ (y >> ((i + 4) % 8)) ^ (y >> ((i + 5) % 8)) ^
              (y >> ((i + 6) % 8)) ^ (y >> ((i + 7) % 8)) ^ (8'h63 >> i)) & 1;
        s = s | (bi << i);
      end
      sbox_m[x] = s[7:0];
      inv_m[s]  = x[7:0];
    end
    e = 1;
    for (int j = 0; j < 255; j++) begin
      pos_m[e] = j;
      e = mmul(e, 3);
    end
  endtask

  function automatic logic [8*NB-1:0] exp_vec(input logic [8*NB-1:0] v);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = inv_m[v[8*i +: 8]];
    return r;
  endfunction

  function automatic int exp_lat(input logic [8*NB-1:0] v);
    int m, l;
    m = 0;
    for (int i = 0; i < NB; i++) begin
      l = (v[8*i +: 8] == 8'h63) ? 1 : pos_m[inv_m[v[8*i +: 8]]] + 1;
      if (l > m) m = l;
    end
    return m;
  endfunction

  function automatic logic [8*NB-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered at #1 after a posedge in IDLE; returns after done or 300 cycles.
  task automatic run_lookup(input logic [8*NB-1:0] v, input bit scramble,
                            output int lat, output int busy_n);
    index  = v;
    enable = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 300) begin
      if (busy) busy_n++;
      if (scramble) index = rand_vec();
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic end_lookup();
    enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    index  = rand_vec();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sbout !== '0) begin errors++; $display("FAIL reset_sbout: got %h required 0", sbout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    resetn = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done); end
  endtask

  task automatic test_min_latency();
    int lat, bn;
    logic [8*NB-1:0] v, e;
    run_lookup({NB{8'h7c}}, 1'b0, lat, bn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL min_lat_7c: got %0d required 1", lat); end
    checks++; if (bn !== 1) begin errors++; $display("FAIL min_busy_7c: got %0d required 1", bn); end
    checks++; if (sbout !== {NB{8'h01}}) begin errors++; $display("FAIL min_sbout_7c: got %h required %h", sbout, {NB{8'h01}}); end
    end_lookup();
    checks++; if (done !== 1'b0 || sbout !== {NB{8'h01}}) begin errors++; $display("FAIL abort_hold: done=%b sbout=%h required 0 and %h", done, sbout, {NB{8'h01}}); end
    v = {8{8'h63, 8'h7c}};
    e = {8{8'h00, 8'h01}};
    run_lookup(v, 1'b0, lat, bn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL min_lat_63: got %0d required 1", lat); end
    checks++; if (sbout !== e || sbout !== exp_vec(v)) begin errors++; $display("FAIL min_sbout_63: got %h required %h", sbout, e); end
    end_lookup();
  endtask

  task automatic test_max_latency();
    int lat, bn;
    logic [8*NB-1:0] v, e, held;
    v = {{12{8'h63}}, 8'h42, 8'h00, 8'h7b, 8'h77};
    e = {{12{8'h00}}, 8'hf6, 8'h52, 8'h03, 8'h02};
    run_lookup(v, 1'b0, lat, bn);
    checks++; if (lat !== 255) begin errors++; $display("FAIL max_lat: got %0d required 255", lat); end
    checks++; if (bn !== 255) begin errors++; $display("FAIL max_busy: got %0d required 255", bn); end
    checks++; if (sbout !== e) begin errors++; $display("FAIL max_sbout: got %h required %h", sbout, e); end
    checks++; if (exp_vec(v) !== e) begin errors++; $display("FAIL model_anchor: got %h required %h", exp_vec(v), e); end
    held = sbout;
    repeat (3) begin
      index = rand_vec();
      @(posedge clk); #1;
    end
    checks++; if (done !== 1'b1 || sbout !== held) begin errors++; $display("FAIL done_hold: done=%b sbout=%h required 1 and %h", done, sbout, held); end
    end_lookup();
  endtask

  task automatic test_exhaustive();
    int perm [256];
    int lat, bn, j, t, bad;
    logic [8*NB-1:0] v;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NB; i++) v[8*i +: 8] = perm[16*k + i][7:0];
      run_lookup(v, 1'b0, lat, bn);
      checks++; if (lat !== exp_lat(v)) begin errors++; $display("FAIL exh_lat[%0d]: got %0d required %0d", k, lat, exp_lat(v)); end
      checks++; if (sbout !== exp_vec(v)) begin errors++; $display("FAIL exh_sbout[%0d]: got %h required %h", k, sbout, exp_vec(v)); end
      bad = 0;
      for (int i = 0; i < NB; i++)
        if (sbox_m[sbout[8*i +: 8]] !== v[8*i +: 8]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL exh_roundtrip[%0d]: %0d lanes with S(sbout)!=index, required 0", k, bad); end
      end_lookup();
    end
  endtask

  task automatic test_abort();
    int lat, bn, dh;
    index  = {NB{8'h42}};
    enable = 1'b1;
    @(posedge clk); #1;
    dh = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) dh++;
    end
    enable = 1'b0;
    @(posedge clk); #1;
    checks++; if (dh !== 0) begin errors++; $display("FAIL abort_no_done: done seen %0d cycles, required 0", dh); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done); end
    run_lookup({NB{8'h7c}}, 1'b0, lat, bn);
    checks++; if (lat !== 1 || sbout !== {NB{8'h01}}) begin errors++; $display("FAIL abort_restart: lat=%0d sbout=%h required 1 and %h", lat, sbout, {NB{8'h01}}); end
    end_lookup();
  endtask

  task automatic test_index_change();
    int lat, bn;
    logic [8*NB-1:0] v;
    for (int k = 0; k < 3; k++) begin
      v = rand_vec();
      run_lookup(v, 1'b1, lat, bn);
      checks++; if (lat !== exp_lat(v)) begin errors++; $display("FAIL idxchg_lat[%0d]: got %0d required %0d", k, lat, exp_lat(v)); end
      checks++; if (sbout !== exp_vec(v)) begin errors++; $display("FAIL idxchg_sbout[%0d]: got %h required %h", k, sbout, exp_vec(v)); end
      end_lookup();
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    logic [8*NB-1:0] v;
    index  = {8{8'h42, 8'h7c}};
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (50) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || sbout === '0) begin errors++; $display("FAIL midscan_state: busy=%b sbout=%h required busy 1 and partial results", busy, sbout); end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (sbout !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid: sbout=%h busy=%b done=%b required 0 0 0", sbout, busy, done); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold: busy=%b required 0", busy); end
    resetn = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    v = rand_vec();
    run_lookup(v, 1'b0, lat, bn);
    checks++; if (lat !== exp_lat(v) || sbout !== exp_vec(v)) begin errors++; $display("FAIL reset_restart: lat=%0d sbout=%h required %0d and %h", lat, sbout, exp_lat(v), exp_vec(v)); end
    end_lookup();
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    logic [8*NB-1:0] v;
    for (int k = 0; k < 6; k++) begin
      v = rand_vec();
      run_lookup(v, 1'b0, lat, bn);
      checks++; if (lat !== exp_lat(v)) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d required %0d", k, lat, exp_lat(v)); end
      checks++; if (bn !== exp_lat(v)) begin errors++; $display("FAIL b2b_busy[%0d]: got %0d required %0d", k, bn, exp_lat(v)); end
      checks++; if (sbout !== exp_vec(v)) begin errors++; $display("FAIL b2b_sbout[%0d]: got %h required %h", k, sbout, exp_vec(v)); end
      end_lookup();
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_min_latency();
    test_max_latency();
    test_exhaustive();
    test_abort();
    test_index_change();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sbox.md
# inv_sbox

Iterative AES inverse S-box for the decryption datapath (InvSubBytes on a full 16-byte state). Walks the GF(256) multiplicative group with generator 0x03 while tracking the field inverse, forms the forward S-box value each cycle, and captures the walk element wherever it matches an input byte. All bytes resolve in parallel within 255 cycles; a level enable/done handshake matches the forward S-box it sits beside.

## Interface
- NBYTES, 16, number of byte lanes resolved in parallel
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- enable  input  1  level request; high starts and holds a lookup, low aborts/clears
- index  input  8*NBYTES  bytes to invert, lane i = index[8i+7:8i]; sampled once at start
- sbout  output  8*NBYTES  InvS(index) per lane, registered
- busy  output  1  high in SCAN
- done  output  1  high in DONE; all lanes valid

## Operation
- States: IDLE, SCAN, DONE. Reset (resetn low at an edge): IDLE, sbout=0, idx_r=0, found=0, p=0x01, q=0x01, cnt=0; busy=0, done=0.
- IDLE, enable=1: capture index into idx_r, sbout=0, found=0, p=q=0x01, cnt=0, go SCAN. IDLE, enable=0: stay.
- SCAN, each cycle: aff = affine(q) with c=0x63, i.e. aff = S(p). Per lane not yet found: idx_r byte == 0x63 -> sbout lane=0x00, found; else idx_r byte == aff -> sbout lane=p, found. Then p <= p*0x03 (reduction 0x1b), q <= q*0xF6 (inverse of 0x03), cnt++.
- Go DONE on the edge where found (including lanes resolved that same edge) is all ones, or cnt reaches 254 (forced exit; unreachable for a bijective S-box, covered by assertion).
- DONE: sbout, done held while enable=1; no further updates.
- enable=0 in SCAN or DONE: next edge -> IDLE, p=q=0x01, found=0; sbout keeps its last value; busy/done drop.
- No special case for index 0x00: InvS(0x00)=0x52 found by the walk.
- Found lanes never overwritten in the same lookup (p walk visits each nonzero element once).

## Timing
- E0 = edge at which IDLE samples enable=1 (index captured). Lane whose result is 0x03^j resolves at edge E(j+1); 0x63 lanes resolve at E1.
- done rises after E(k), k = max lane position; min latency 1 cycle (all lanes 0x63 or 0x7c), max 255 (lane 0x42 -> 0xF6 = 0x03^254).
- busy high from after E0 to the edge done rises; busy and done never both high.
- enable low for one cycle fully aborts; the next enable high re-captures index.
- resetn low overrides enable at any state.

## Structure
- aes_pkg: AES_SBOX_C (8'h63), GF_POLY_LOW (8'h1b), GF_GEN (8'h03), GF_GEN_INV (8'hF6), state enum.
- One sub-module gf256_walk: holds p/q registers, clear/step controls, outputs p and aff = S(p); reusable by the forward S-box.
- Lane compare/capture logic in a generate loop over NBYTES in inv_sbox.

## Test plan
- All 16 lanes 0x7c, enable held -> done after E1, all sbout lanes 0x01; lane 0x63 -> 0x00 in same cycle.
- Lanes {0x77, 0x7b, 0x00, 0x42, rest 0x63} -> sbout {0x02, 0x03, 0x52, 0xF6, 0x00}; done after E255, busy high for 255 cycles.
- Exhaustive: 16 consecutive lookups covering all 256 byte values -> each matches InvSbox table and S(sbout)==index.
- enable dropped at cycle 100 of a 0x42 lookup -> IDLE next edge, done never asserted; re-enable with 0x7c lanes -> 0x01, done after E1.
- index changed during SCAN and DONE -> no effect on sbout (captured at E0 only).
- resetn low mid-SCAN -> next edge all outputs 0, state IDLE; lookup restarts cleanly after release.
